// File: rtl/taglist_pkg.sv
// Shared definitions for the tag-list builder and sequencer: entry field
// positions, sequencer state encoding and error codes.
package taglist_pkg;

    // Tag-list entry layout: {unused, seq, first, last, end}
    localparam int SEQ_HI   = 27;
    localparam int SEQ_LO   = 21;
    localparam int FIRST_HI = 20;
    localparam int FIRST_LO = 11;
    localparam int LAST_HI  = 10;
    localparam int LAST_LO  = 1;
    localparam int END_BIT  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_PLAY  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } seq_state_e;

    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_NOT_READY    = 2'd1;
    localparam logic [1:0] ERR_SEQ_MISMATCH = 2'd2;
    localparam logic [1:0] ERR_BAD_RANGE    = 2'd3;

endpackage

// File: rtl/taglist_entry_decode.sv
// Combinational split of a tag-list entry into its fields plus the
// sequence-number and address-range sanity checks.
module taglist_entry_decode
    import taglist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SEQ_W  = 7,
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] entry,
    input  logic [SEQ_W-1:0]  seq,
    output logic [ADDR_W-1:0] first,
    output logic [ADDR_W-1:0] last,
    output logic              end_flag,
    output logic              seq_ok,
    output logic              range_ok
);

    // Bits above the sequence field carry nothing for playback
    logic unused_high_bits;
    assign unused_high_bits = ^entry[DATA_W-1:SEQ_HI+1];

    assign first    = entry[FIRST_HI:FIRST_LO];
    assign last     = entry[LAST_HI:LAST_LO];
    assign end_flag = entry[END_BIT];
    assign seq_ok   = (entry[SEQ_HI:SEQ_LO] == seq);
    assign range_ok = (first <= last);

endmodule

// File: rtl/taglist_sequencer.sv
// Playback controller: fetches one tag-list entry, validates it and then
// steps the ROM address from first to last, one address per handshake.
module taglist_sequencer
    import taglist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SEQ_W  = 7,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_1KHz,
    input  logic              reset,
    input  logic              tl_done,
    input  logic              start,
    input  logic [SEQ_W-1:0]  seq_sel,
    input  logic              abort,
    output logic              ram_rd_en,
    output logic [SEQ_W-1:0]  ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_valid,
    input  logic              rom_ready,
    output logic              rom_last,
    output logic              end_flag,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    seq_state_e        state_q, state_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [DATA_W-1:0] entry_q, entry_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic              end_q, end_d;
    logic [1:0]        code_q, code_d;
    logic [1:0]        wait_q, wait_d;

    logic [ADDR_W-1:0] dec_first, dec_last;
    logic              dec_end, dec_seq_ok, dec_range_ok;
    logic              is_busy;

    taglist_entry_decode #(
        .ADDR_W (ADDR_W),
        .SEQ_W  (SEQ_W),
        .DATA_W (DATA_W)
    ) u_decode (
        .entry    (entry_q),
        .seq      (seq_q),
        .first    (dec_first),
        .last     (dec_last),
        .end_flag (dec_end),
        .seq_ok   (dec_seq_ok),
        .range_ok (dec_range_ok)
    );

    assign is_busy = (state_q != ST_IDLE) && (state_q != ST_ERR);

    // State and datapath registers; asynchronous reset returns everything to idle
    always_ff @(posedge clk_1KHz or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            entry_q <= '0;
            cur_q   <= '0;
            end_q   <= 1'b0;
            code_q  <= ERR_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            entry_q <= entry_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            code_q  <= code_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; abort overrides everything while busy, and a start
    // arriving with abort is dropped in the idle/error states
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        entry_d = entry_q;
        cur_d   = cur_q;
        end_d   = end_q;
        code_d  = code_q;
        wait_d  = wait_q;

        if (abort && is_busy) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERR: begin
                    if (start && !abort) begin
                        if (!tl_done) begin
                            state_d = ST_ERR;
                            code_d  = ERR_NOT_READY;
                        end else begin
                            seq_d   = seq_sel;
                            code_d  = ERR_NONE;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    // Read data lands on the final wait cycle
                    if (wait_q == 2'(RD_LAT - 1)) begin
                        entry_d = ram_rd_data;
                        state_d = ST_CHECK;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
                ST_CHECK: begin
                    if (!dec_seq_ok) begin
                        state_d = ST_ERR;
                        code_d  = ERR_SEQ_MISMATCH;
                    end else if (!dec_range_ok) begin
                        state_d = ST_ERR;
                        code_d  = ERR_BAD_RANGE;
                    end else begin
                        cur_d   = dec_first;
                        end_d   = dec_end;
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // Stop on the last address rather than incrementing, so no wrap
                    if (rom_ready) begin
                        if (cur_q == dec_last) begin
                            state_d = ST_DONE;
                        end else begin
                            cur_d = cur_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign ram_rd_en   = (state_q == ST_FETCH);
    assign ram_rd_addr = seq_q;
    assign rom_valid   = (state_q == ST_PLAY);
    assign rom_addr    = cur_q;
    assign rom_last    = (state_q == ST_PLAY) && (cur_q == dec_last);
    assign end_flag    = end_q;
    assign busy        = is_busy;
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERR);
    assign err_code    = code_q;

endmodule

// File: tb/tb_taglist_sequencer.sv
// Self-checking bench for taglist_sequencer: table of entries played back
// against a scoreboard of expected ROM addresses, plus hand sequences for
// not-ready, abort, mid-play start and reset-in-flight.
module tb_taglist_sequencer;

    logic        clk_1KHz = 1'b0;
    logic        reset;
    logic        tl_done;
    logic        start;
    logic [6:0]  seq_sel;
    logic        abort;
    logic        ram_rd_en;
    logic [6:0]  ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic [9:0]  rom_addr;
    logic        rom_valid;
    logic        rom_ready;
    logic        rom_last;
    logic        end_flag;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;

    logic [31:0] mem [128];
    logic [31:0] ram_q = '0;
    logic [9:0]  exp_q [$];

    typedef struct {
        logic [6:0] seq;
        logic [6:0] ent_seq;
        logic [9:0] first;
        logic [9:0] last;
        logic       endb;
        bit         toggle;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs [6];

    taglist_sequencer dut (
        .clk_1KHz    (clk_1KHz),
        .reset       (reset),
        .tl_done     (tl_done),
        .start       (start),
        .seq_sel     (seq_sel),
        .abort       (abort),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .rom_addr    (rom_addr),
        .rom_valid   (rom_valid),
        .rom_ready   (rom_ready),
        .rom_last    (rom_last),
        .end_flag    (end_flag),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk_1KHz = ~clk_1KHz;

    // One-cycle-latency RAM model and read-enable counter
    always @(posedge clk_1KHz) begin
        if (ram_rd_en) begin
            ram_q  <= mem[ram_rd_addr];
            rd_cnt <= rd_cnt + 1;
        end
    end
    assign ram_rd_data = ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {6'd0, ram_rd_en, ram_rd_addr, rom_addr, rom_valid, rom_last,
                end_flag, busy, done, err, err_code};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int         cyc;
        int         n_acc;
        int         last_acc;
        bit         seen;
        bit         finished;
        logic [1:0] outcome;
        logic [9:0] ex;

        mem[v.seq] = {4'b0, v.ent_seq, v.first, v.last, v.endb};
        exp_q.delete();
        if (v.exp_code == 2'd0) begin
            for (int a = int'(v.first); a <= int'(v.last); a++) exp_q.push_back(10'(a));
        end

        @(negedge clk_1KHz);
        start     = 1'b1;
        seq_sel   = v.seq;
        rom_ready = 1'b0;
        @(negedge clk_1KHz);
        start = 1'b0;
        cyc   = 1;
        chk("err_cleared_on_start", {30'd0, err, err_code}, 32'd0);
        chk("busy_in_fetch", busy, 1);

        finished = 0;
        seen     = 0;
        n_acc    = 0;
        last_acc = -10;
        outcome  = 2'd0;
        while (!finished && cyc < 60) begin
            rom_ready = v.toggle ? ~rom_ready : 1'b1;
            if (rom_valid && !seen) begin
                seen = 1;
                chk("first_valid_latency", cyc, 4);
            end
            if (done) begin
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_after_last_accept", last_acc, cyc - 1);
                outcome  = 2'd0;
                finished = 1;
            end else if (err) begin
                chk("err_not_busy", busy, 0);
                outcome  = err_code;
                finished = 1;
            end else if (rom_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rom_valid", rom_addr, 32'hFFFF_FFFF);
                end else if (rom_ready) begin
                    ex = exp_q.pop_front();
                    chk("rom_addr", rom_addr, ex);
                    chk("rom_last", rom_last, exp_q.size() == 0);
                    chk("end_flag", end_flag, v.endb);
                    if (!v.toggle) chk("throughput_cycle", cyc, 4 + n_acc);
                    n_acc++;
                    last_acc = cyc;
                end else begin
                    chk("addr_held_while_stalled", rom_addr, exp_q[0]);
                end
            end
            if (!finished) begin
                @(negedge clk_1KHz);
                cyc++;
            end
        end
        chk("vec_finished", finished, 1);
        chk("outcome_code", outcome, v.exp_code);
        rom_ready = 1'b0;
        @(negedge clk_1KHz);
        chk("done_one_cycle", done, 0);
        $display("vec %0d seq %0d first %03h last %03h -> code %0d, %0d addresses, %0d cycles",
                 idx, v.seq, v.first, v.last, outcome, n_acc, cyc);
    endtask

    initial begin
        int rd0;

        vecs[0] = '{7'd5,  7'd5,  10'h010, 10'h013, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{7'd5,  7'd5,  10'h010, 10'h013, 1'b0, 1'b1, 2'd0};
        vecs[2] = '{7'd2,  7'd7,  10'h010, 10'h013, 1'b0, 1'b0, 2'd2};
        vecs[3] = '{7'd9,  7'd9,  10'h020, 10'h01F, 1'b0, 1'b0, 2'd3};
        vecs[4] = '{7'd10, 7'd10, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 2'd0};
        vecs[5] = '{7'd12, 7'd12, 10'h100, 10'h102, 1'b1, 1'b1, 2'd0};
        for (int i = 0; i < 128; i++) mem[i] = 32'hDEAD_0000 | i;

        reset     = 1'b0;
        tl_done   = 1'b1;
        start     = 1'b0;
        seq_sel   = '0;
        abort     = 1'b0;
        rom_ready = 1'b0;

        @(negedge clk_1KHz);
        chk("reset_outputs", all_outs(), 32'd0);
        reset = 1'b1;
        @(negedge clk_1KHz);
        chk("idle_after_reset", all_outs(), 32'd0);

        // Not ready: start with tl_done low never touches the RAM
        rd0     = rd_cnt;
        tl_done = 1'b0;
        start   = 1'b1;
        seq_sel = 7'd3;
        @(negedge clk_1KHz);
        start = 1'b0;
        chk("not_ready_err", err, 1);
        chk("not_ready_code", err_code, 1);
        chk("not_ready_busy", busy, 0);
        @(negedge clk_1KHz);
        chk("not_ready_no_read", rd_cnt, rd0);
        $display("not-ready start seq 3 -> err %0d code %0d", err, err_code);
        tl_done = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Abort together with start from idle: start dropped
        @(negedge clk_1KHz);
        start   = 1'b1;
        abort   = 1'b1;
        seq_sel = 7'd5;
        @(negedge clk_1KHz);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle_busy", busy, 0);
        chk("abort_start_idle_rden", ram_rd_en, 0);
        $display("abort+start from idle -> busy %0d", busy);

        // Mid-play start ignored, abort on second PLAY cycle
        @(negedge clk_1KHz);
        start   = 1'b1;
        seq_sel = 7'd5;
        @(negedge clk_1KHz);
        start = 1'b0;
        repeat (3) @(negedge clk_1KHz);
        chk("play_cycle1_valid", rom_valid, 1);
        rd0     = rd_cnt;
        start   = 1'b1;
        seq_sel = 7'd9;
        @(negedge clk_1KHz);
        start = 1'b0;
        chk("play_cycle2_valid", rom_valid, 1);
        chk("play_cycle2_addr", rom_addr, 10'h010);
        chk("midplay_start_no_fetch", rd_cnt, rd0);
        abort = 1'b1;
        @(negedge clk_1KHz);
        abort = 1'b0;
        chk("abort_valid_drop", rom_valid, 0);
        chk("abort_idle", {busy, done, err}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_1KHz);
            chk("abort_no_done", done, 0);
        end
        $display("abort during play -> valid %0d busy %0d", rom_valid, busy);

        // Reset asserted during WAIT after a playback that left end_flag set
        run_vec(vecs[4], 4);
        @(negedge clk_1KHz);
        start   = 1'b1;
        seq_sel = 7'd5;
        @(negedge clk_1KHz);
        start = 1'b0;
        @(negedge clk_1KHz);
        chk("busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 32'd0);
        @(negedge clk_1KHz);
        chk("reset_held_outputs", all_outs(), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_1KHz);
            chk("after_reset_quiet", {busy, done}, 2'b00);
        end
        $display("reset during wait -> outputs %0h", all_outs());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
